// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - state, framing and error-code definitions shared by the program loader
package instr_loader_pkg;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    LEN_LO,
    LEN_HI,
    PAYLOAD,
    CHECKSUM,
    DONE,
    ERROR
  } loader_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_CHECKSUM = 2'd3;

  // Once a frame has started the sender must keep bytes coming; idle is only legal outside a frame.
  function automatic logic timeout_running(input loader_state_e s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == PAYLOAD) || (s == CHECKSUM);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// rtl/loader_timeout.sv - inter-byte idle counter with clear/enable and a terminal-count flag
module loader_timeout
  import instr_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at the terminal value so tc stays asserted until the owner reacts.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q != TERMINAL) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en && (cnt_q == TERMINAL);

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - parses a framed UART boot image into byte writes and releases the CPU once verified
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int          INSTR_SIZE     = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        reload,
  output logic        instr_wr_en,
  output logic [31:0] instr_wr_addr,
  output logic [7:0]  instr_wr_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [1:0]  err_code
);

  localparam logic [31:0] MAX_LEN = 32'(4 * INSTR_SIZE);

  loader_state_e state_q, state_d;
  logic [7:0]    len_lo_q, len_lo_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic          wr_en_q, wr_en_d;
  logic [31:0]   wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          hold_q, hold_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [1:0]    code_q, code_d;

  logic [15:0]   len_rx;
  logic          tmo_en, tmo_clr, tmo_tc;

  assign len_rx  = {rx_data, len_lo_q};
  assign tmo_en  = timeout_running(state_q);
  assign tmo_clr = rx_valid || reload;

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr(tmo_clr),
    .en (tmo_en),
    .tc (tmo_tc)
  );

  always_comb begin
    state_d   = state_q;
    len_lo_d  = len_lo_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    done_d    = done_q;
    error_d   = error_q;
    code_d    = code_q;

    if (reload) begin
      state_d   = WAIT_SYNC;
      hold_d    = 1'b1;
      done_d    = 1'b0;
      error_d   = 1'b0;
      code_d    = ERR_NONE;
      wr_addr_d = BASE_ADDR;
    end else begin
      unique case (state_q)
        WAIT_SYNC: begin
          if (rx_valid && rx_data == SYNC_BYTE) state_d = LEN_LO;
        end
        LEN_LO: begin
          if (rx_valid) begin
            len_lo_d = rx_data;
            state_d  = LEN_HI;
          end
        end
        LEN_HI: begin
          if (rx_valid) begin
            if (len_rx == 16'd0 || 32'(len_rx) > MAX_LEN) begin
              state_d = ERROR;
              hold_d  = 1'b1;
              error_d = 1'b1;
              code_d  = ERR_BAD_LEN;
            end else begin
              len_d   = len_rx;
              cnt_d   = 16'd0;
              sum_d   = 8'd0;
              state_d = PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (rx_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = BASE_ADDR + 32'(cnt_q);
            wr_data_d = rx_data;
            sum_d     = sum_q + rx_data;
            cnt_d     = cnt_q + 16'd1;
            if (cnt_q == len_q - 16'd1) state_d = CHECKSUM;
          end
        end
        CHECKSUM: begin
          if (rx_valid) begin
            if (rx_data == sum_q) begin
              state_d = DONE;
              hold_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = ERROR;
              hold_d  = 1'b1;
              error_d = 1'b1;
              code_d  = ERR_CHECKSUM;
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        ERROR: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state_d = LEN_LO;
            error_d = 1'b0;
            code_d  = ERR_NONE;
          end
        end
        default: begin
          state_d = WAIT_SYNC;
        end
      endcase

      // A byte arriving on the terminal count keeps the frame alive.
      if (tmo_tc && !rx_valid) begin
        state_d = ERROR;
        hold_d  = 1'b1;
        error_d = 1'b1;
        code_d  = ERR_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_SYNC;
      len_lo_q  <= 8'd0;
      len_q     <= 16'd0;
      cnt_q     <= 16'd0;
      sum_q     <= 8'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE_ADDR;
      wr_data_q <= 8'd0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      code_q    <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      len_lo_q  <= len_lo_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      error_q   <= error_d;
      code_q    <= code_d;
    end
  end

  assign instr_wr_en   = wr_en_q;
  assign instr_wr_addr = wr_addr_q;
  assign instr_wr_data = wr_data_q;
  assign cpu_hold      = hold_q;
  assign load_done     = done_q;
  assign load_error    = error_q;
  assign err_code      = code_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - directed self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        reload;
  logic        instr_wr_en;
  logic [31:0] instr_wr_addr;
  logic [7:0]  instr_wr_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  logic [7:0] nom [8] = '{8'hb7, 8'h00, 8'h00, 8'h40, 8'h03, 8'ha1, 8'h00, 8'h00};

  instr_mem_loader #(
    .INSTR_SIZE    (4),
    .BASE_ADDR     (BASE),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .reload       (reload),
    .instr_wr_en  (instr_wr_en),
    .instr_wr_addr(instr_wr_addr),
    .instr_wr_data(instr_wr_data),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_error   (load_error),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic status(input string tag, input logic h, input logic d, input logic e,
                        input logic [1:0] c);
    check({tag, ".cpu_hold"},   32'(cpu_hold),   32'(h));
    check({tag, ".load_done"},  32'(load_done),  32'(d));
    check({tag, ".load_error"}, 32'(load_error), 32'(e));
    check({tag, ".err_code"},   32'(err_code),   32'(c));
  endtask

  // Called at a falling edge: presents one byte for exactly one cycle, then checks the write port.
  task automatic send(input logic [7:0] b, input bit exp_wr, input int idx, input string tag);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    check({tag, ".wr_en"}, 32'(instr_wr_en), 32'(exp_wr));
    if (exp_wr) begin
      check({tag, ".wr_addr"}, instr_wr_addr, BASE + 32'(idx));
      check({tag, ".wr_data"}, 32'(instr_wr_data), 32'(b));
    end
  endtask

  task automatic send_frame(input logic [7:0] csum, input string tag);
    send(8'hA5, 1'b0, 0, tag);
    send(8'h08, 1'b0, 0, tag);
    send(8'h00, 1'b0, 0, tag);
    for (int i = 0; i < 8; i++) send(nom[i], 1'b1, i, tag);
    send(csum, 1'b0, 0, tag);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reload   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.wr_en", 32'(instr_wr_en), 32'd0);
    check("reset.wr_addr", instr_wr_addr, BASE);
    check("reset.wr_data", 32'(instr_wr_data), 32'd0);
    status("reset", 1'b1, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;
    @(negedge clk);

    // Garbage before sync, then a nominal image.
    send(8'h00, 1'b0, 0, "garbage0");
    send(8'hFF, 1'b0, 0, "garbage1");
    send(8'h5A, 1'b0, 0, "garbage2");
    send_frame(8'h9B, "nominal");
    status("nominal", 1'b0, 1'b1, 1'b0, 2'd0);
    send(8'hA5, 1'b0, 0, "done_ignore");
    status("done_ignore", 1'b0, 1'b1, 1'b0, 2'd0);

    pulse_reload();
    status("reload", 1'b1, 1'b0, 1'b0, 2'd0);
    check("reload.wr_addr", instr_wr_addr, BASE);

    // Length of zero, then one byte over the 16-byte limit, then exactly the limit.
    send(8'hA5, 1'b0, 0, "len0");
    send(8'h00, 1'b0, 0, "len0");
    send(8'h00, 1'b0, 0, "len0");
    status("len0", 1'b1, 1'b0, 1'b1, 2'd1);
    send(8'hA5, 1'b0, 0, "resync");
    status("resync", 1'b1, 1'b0, 1'b0, 2'd0);
    send(8'h11, 1'b0, 0, "len17");
    send(8'h00, 1'b0, 0, "len17");
    status("len17", 1'b1, 1'b0, 1'b1, 2'd1);
    send(8'hA5, 1'b0, 0, "len16");
    send(8'h10, 1'b0, 0, "len16");
    send(8'h00, 1'b0, 0, "len16");
    status("len16", 1'b1, 1'b0, 1'b0, 2'd0);
    send(8'h5C, 1'b1, 0, "len16_byte0");
    pulse_reload();

    // Bad checksum leaves written bytes and errors; a fresh frame recovers.
    send_frame(8'h9C, "badsum");
    status("badsum", 1'b1, 1'b0, 1'b1, 2'd3);
    send_frame(8'h9B, "recover");
    status("recover", 1'b0, 1'b1, 1'b0, 2'd0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    status("rst_from_done", 1'b1, 1'b0, 1'b0, 2'd0);

    // Silence after one payload byte: error lands on the 16th idle cycle.
    send(8'hA5, 1'b0, 0, "tmo");
    send(8'h04, 1'b0, 0, "tmo");
    send(8'h00, 1'b0, 0, "tmo");
    send(8'h01, 1'b1, 0, "tmo");
    repeat (15) @(negedge clk);
    status("tmo_idle15", 1'b1, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    status("tmo_idle16", 1'b1, 1'b0, 1'b1, 2'd2);

    // Each byte arrives exactly on the terminal count and must win.
    pulse_reload();
    send(8'hA5, 1'b0, 0, "tc");
    send(8'h04, 1'b0, 0, "tc");
    send(8'h00, 1'b0, 0, "tc");
    send(8'h01, 1'b1, 0, "tc");
    repeat (15) @(negedge clk);
    send(8'h02, 1'b1, 1, "tc_b1");
    status("tc_b1", 1'b1, 1'b0, 1'b0, 2'd0);
    repeat (15) @(negedge clk);
    send(8'h03, 1'b1, 2, "tc_b2");
    repeat (15) @(negedge clk);
    send(8'h04, 1'b1, 3, "tc_b3");
    repeat (15) @(negedge clk);
    send(8'h0A, 1'b0, 0, "tc_sum");
    status("tc_sum", 1'b0, 1'b1, 1'b0, 2'd0);

    // Reload coinciding with a payload byte drops the byte.
    pulse_reload();
    send(8'hA5, 1'b0, 0, "rl");
    send(8'h04, 1'b0, 0, "rl");
    send(8'h00, 1'b0, 0, "rl");
    send(8'h11, 1'b1, 0, "rl");
    send(8'h22, 1'b1, 1, "rl");
    reload   = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    @(negedge clk);
    reload   = 1'b0;
    rx_valid = 1'b0;
    check("rl_drop.wr_en", 32'(instr_wr_en), 32'd0);
    check("rl_drop.wr_addr", instr_wr_addr, BASE);
    status("rl_drop", 1'b1, 1'b0, 1'b0, 2'd0);
    send(8'h44, 1'b0, 0, "rl_waitsync");
    repeat (20) @(negedge clk);
    status("rl_no_timeout", 1'b1, 1'b0, 1'b0, 2'd0);

    // Reset in the middle of a payload.
    send(8'hA5, 1'b0, 0, "rstmid");
    send(8'h08, 1'b0, 0, "rstmid");
    send(8'h00, 1'b0, 0, "rstmid");
    send(8'hb7, 1'b1, 0, "rstmid");
    send(8'h40, 1'b1, 1, "rstmid");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid.wr_en", 32'(instr_wr_en), 32'd0);
    check("rstmid.wr_addr", instr_wr_addr, BASE);
    check("rstmid.wr_data", 32'(instr_wr_data), 32'd0);
    status("rstmid", 1'b1, 1'b0, 1'b0, 2'd0);
    send(8'h03, 1'b0, 0, "rstmid_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Boot-time program loader that sits directly upstream of the instruction memory's byte-wide write port.
- Consumes a byte stream from the UART receiver and parses a framed image: sync byte, 16-bit length, payload, checksum.
- Emits one byte write per payload byte into instruction memory.
- Holds the CPU in reset until a complete, checksum-valid image has been loaded.

Parameters:
- INSTR_SIZE, 1024: instruction memory depth in 32-bit words; maximum payload is 4*INSTR_SIZE bytes.
- BASE_ADDR, 32'h0000_0000: byte address of the first payload byte.
- TIMEOUT_CYCLES, 1_000_000: maximum idle clocks between bytes once a frame has started.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- reload  in  1  one-cycle pulse: abandon the current state and wait for a new frame.
- instr_wr_en  out  1  byte write strobe to instruction memory.
- instr_wr_addr  out  32  byte address of the write; bits [1:0] select the byte lane (little-endian).
- instr_wr_data  out  8  byte to write.
- cpu_hold  out  1  high means the core is held in reset.
- load_done  out  1  image loaded and verified.
- load_error  out  1  sticky error flag.
- err_code  out  2  error cause: 0 none, 1 bad length, 2 timeout, 3 checksum.

Behaviour:
- Reset values: instr_wr_en=0, instr_wr_addr=BASE_ADDR, instr_wr_data=0, cpu_hold=1, load_done=0, load_error=0, err_code=0, state=WAIT_SYNC.
- WAIT_SYNC:
  - rx_valid with rx_data==8'hA5 -> LEN_LO.
  - Any other byte is ignored.
  - The timeout counter is not running in this state.
- LEN_LO: the next byte is len[7:0] -> LEN_HI.
- LEN_HI: the next byte is len[15:8].
  - If len==0 or len>4*INSTR_SIZE -> ERROR, err_code=1.
  - Otherwise -> PAYLOAD; byte counter=0, checksum accumulator=0.
- PAYLOAD:
  - Each accepted byte produces instr_wr_en=1 on the following cycle, with instr_wr_addr=BASE_ADDR+byte_index and instr_wr_data=byte.
  - Write latency is exactly 1 cycle.
  - instr_wr_en is a single-cycle pulse per byte; back-to-back rx_valid gives back-to-back pulses.
  - The accumulator adds the byte mod 256.
  - After byte len-1 -> CHECKSUM.
- CHECKSUM: the next byte is compared with the accumulator.
  - Equal -> DONE.
  - Unequal -> ERROR, err_code=3.
  - No write is issued for the checksum byte.
- DONE:
  - cpu_hold=0 and load_done=1, effective the cycle after the checksum byte.
  - All further rx bytes are ignored.
- ERROR:
  - load_error=1 and cpu_hold=1.
  - Bytes already written stay in memory; the state is not rolled back.
  - A sync byte 8'hA5 restarts at LEN_LO and clears load_error and err_code.
- Timeout:
  - The counter runs in LEN_LO, LEN_HI, PAYLOAD and CHECKSUM.
  - It clears on every accepted byte.
  - Reaching TIMEOUT_CYCLES-1 -> ERROR, err_code=2.
  - If the terminal count and rx_valid occur in the same cycle, the byte wins and the counter clears.
- reload (from any state):
  - -> WAIT_SYNC; cpu_hold=1, load_done=0, load_error=0, err_code=0, instr_wr_addr=BASE_ADDR.
  - reload together with rx_valid: reload wins and the byte is dropped.
- rst mid-frame: immediate return to reset values; a partially written image is left as-is, and cpu_hold=1.
- Widths: byte counter 16 bits; address = BASE_ADDR + zero-extended counter, wrapping modulo 2^32.

Decomposition:
- Package instr_loader_pkg holds:
  - the state enum (WAIT_SYNC, LEN_LO, LEN_HI, PAYLOAD, CHECKSUM, DONE, ERROR);
  - SYNC_BYTE=8'hA5;
  - the err_code constants.
- One sub-module, loader_timeout: a clear/enable counter with a terminal-count output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Nominal load:
  - Stimulus: A5 08 00, then payload b7 00 00 40 03 a1 00 00, checksum 9B.
  - Response: 8 writes at addresses 0..7 with those bytes, each 1 cycle after its rx_valid; then load_done=1, cpu_hold=0.
- Garbage before sync:
  - Stimulus: 00 FF 5A, then the nominal frame.
  - Response: no writes for the leading bytes; result identical to the nominal load.
- Bad length:
  - Stimulus: A5 00 00.
  - Response: load_error=1, err_code=1, no writes.
  - Stimulus, with INSTR_SIZE=4: A5 11 00.
  - Response: err_code=1.
- Checksum fail:
  - Stimulus: nominal frame with checksum 9C.
  - Response: 8 writes occur, then load_error=1, err_code=3, cpu_hold stays 1.
  - Follow-up: a fresh nominal frame.
  - Response: error clears and load_done=1.
- Timeout:
  - Stimulus (TIMEOUT_CYCLES=16): A5 04 00 01, then silence.
  - Response: err_code=2 after 16 idle cycles.
  - Stimulus: the same frame with rx_valid landing exactly on the terminal count.
  - Response: no error.
- Reload/reset:
  - Stimulus: reload pulsed together with rx_valid in PAYLOAD.
  - Response: byte dropped, state WAIT_SYNC, cpu_hold=1.
  - Stimulus: rst mid-PAYLOAD.
  - Response: all outputs at their reset values the next cycle.
